// File: rtl/quad_gen_if.sv
// Command channel for quad_gen: signed step count plus edge spacing.
// The master issues moves; the generator accepts them when idle.
interface quad_gen_if #(
  parameter int WIDTH    = 32,
  parameter int PERIOD_W = 16
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic [WIDTH-1:0]    cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_gen.sv
// Quadrature A/B generator: emits signed step moves as gray-coded
// edges at a programmed clock spacing and tracks emitted position.
module quad_gen #(
  parameter int WIDTH    = 32,
  parameter int PERIOD_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  quad_gen_if.slave               cmd,
  input  logic                    abort,
  output logic                    a,
  output logic                    b,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] position
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t              state;
  logic [1:0]          phase;
  logic                dir;
  logic                zero_pend;
  logic [WIDTH-1:0]    remaining;
  logic [PERIOD_W-1:0] per;
  logic [PERIOD_W-1:0] timer;

  logic [WIDTH-1:0]    mag;
  logic [PERIOD_W-1:0] per_in;
  logic [1:0]          ph_nx;

  // Unsigned magnitude keeps the most negative step count representable.
  assign mag = cmd.cmd_steps[WIDTH-1] ? -cmd.cmd_steps
                                      : cmd.cmd_steps;

  assign per_in = (cmd.cmd_period < PERIOD_W'(2))
                ? PERIOD_W'(2) : cmd.cmd_period;

  assign ph_nx = dir ? phase - 2'd1 : phase + 2'd1;

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      phase     <= 2'd0;
      dir       <= 1'b0;
      zero_pend <= 1'b0;
      remaining <= '0;
      per       <= PERIOD_W'(2);
      timer     <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      done      <= 1'b0;
      position  <= '0;
    end else begin
      done      <= zero_pend;
      zero_pend <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            if (cmd.cmd_steps == '0) begin
              zero_pend <= 1'b1;
            end else begin
              remaining <= mag;
              dir       <= cmd.cmd_steps[WIDTH-1];
              per       <= per_in;
              timer     <= per_in - PERIOD_W'(1);
              state     <= RUN;
            end
          end
        end
        RUN: begin
          // Abort beats a coincident expiry: that edge is dropped.
          if (abort) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (timer == '0) begin
            phase     <= ph_nx;
            a         <= ph_nx[1] ^ ph_nx[0];
            b         <= ph_nx[1];
            position  <= dir ? position - WIDTH'(1)
                             : position + WIDTH'(1);
            remaining <= remaining - WIDTH'(1);
            timer     <= per - PERIOD_W'(1);
            if (remaining == WIDTH'(1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            timer <= timer - PERIOD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen: cycle-exact move model plus
// a behavioural quadrature decoder watching the A/B outputs.
module tb_quad_gen;

  logic        clk;
  logic        resetn;
  logic        abort;
  logic        a;
  logic        b;
  logic        busy;
  logic        done;
  logic signed [31:0] position;

  quad_gen_if #(.WIDTH(32), .PERIOD_W(16)) ifc ();

  quad_gen #(
    .WIDTH   (32),
    .PERIOD_W(16)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .cmd     (ifc),
    .abort   (abort),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .position(position)
  );

  int checks = 0;
  int errors = 0;

  int m_phase = 0;
  int m_pos   = 0;

  int   dec_cnt;
  logic dec_fault;
  logic [1:0] dec_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap4(input longint x);
    return int'(((x % 4) + 4) % 4);
  endfunction

  function automatic logic [1:0] ab_of(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int ph_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference decoder: counts gray steps, flags double transitions.
  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_cnt   <= 0;
      dec_fault <= 1'b0;
      dec_prev  <= 2'b00;
    end else begin
      case (wrap4(ph_of({a, b}) - ph_of(dec_prev)))
        1:       dec_cnt <= dec_cnt + 1;
        3:       dec_cnt <= dec_cnt - 1;
        2:       dec_fault <= 1'b1;
        default: ;
      endcase
      dec_prev <= {a, b};
    end
  end

  task automatic run_move(input string name, input longint steps,
                          input int period, input int abort_edge);
    longint n, m, e, lim;
    int per, dir;
    logic aborting;
    logic [36:0] got, exp;
    n   = (steps < 0) ? -steps : steps;
    per = (period < 2) ? 2 : period;
    dir = (steps < 0) ? -1 : 1;
    aborting = (abort_edge > 0) && (abort_edge <= n);
    if (aborting) begin
      m   = abort_edge - 1;
      lim = longint'(abort_edge) * per;
    end else begin
      m   = n;
      lim = n * per;
    end
    checks++;
    if (ifc.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_pre got=%b exp=1", name, ifc.cmd_ready);
    end
    ifc.cmd_valid  = 1'b1;
    ifc.cmd_steps  = 32'(steps);
    ifc.cmd_period = 16'(period);
    @(posedge clk);
    #1;
    ifc.cmd_valid  = 1'b0;
    ifc.cmd_steps  = $urandom;
    ifc.cmd_period = 16'($urandom_range(0, 3));
    if (n == 0) begin
      for (int k = 1; k <= 2; k++) begin
        @(posedge clk);
        #1;
        got = {a, b, busy, done, ifc.cmd_ready, position};
        exp = {ab_of(m_phase), 1'b0, (k == 1), 1'b1, 32'(m_pos)};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
        end
      end
    end else begin
      for (longint k = 1; k <= lim; k++) begin
        @(posedge clk);
        #1;
        if (aborting && k == lim - 1) abort = 1'b1;
        if (k == lim) abort = 1'b0;
        e = (k < lim) ? k / per : m;
        if (e > m) e = m;
        exp = {ab_of(wrap4(m_phase + dir * e)), (k < lim),
               (k == lim), (k == lim), 32'(m_pos + dir * e)};
        got = {a, b, busy, done, ifc.cmd_ready, position};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
        end
      end
    end
    m_phase = wrap4(m_phase + dir * m);
    m_pos   = int'(m_pos + dir * m);
  endtask

  task automatic check_idle(input string name, input int cycles);
    logic [36:0] got, exp;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      got = {a, b, busy, done, ifc.cmd_ready, position};
      exp = {ab_of(m_phase), 1'b0, 1'b0, 1'b1, 32'(m_pos)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s idle k=%0d got=%h exp=%h", name, k, got, exp);
      end
    end
  endtask

  task automatic test_reset;
    logic [36:0] got;
    resetn = 1'b0;
    abort  = 1'b0;
    ifc.cmd_valid  = 1'b0;
    ifc.cmd_steps  = '0;
    ifc.cmd_period = '0;
    #7;
    got = {a, b, busy, done, ifc.cmd_ready, position};
    checks++;
    if (got !== {5'b00001, 32'd0}) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", got, {5'b00001, 32'd0});
    end
    @(negedge clk);
    resetn = 1'b1;
    m_phase = 0;
    m_pos   = 0;
    check_idle("reset_release", 2);
  endtask

  task automatic test_basic;
    run_move("fwd4_p3", 4, 3, 0);
    check_idle("fwd4_after", 1);
    run_move("rev3_p2", -3, 2, 0);
    check_idle("rev3_after", 1);
  endtask

  task automatic test_clamp_zero;
    run_move("clamp_p0", 2, 0, 0);
    run_move("clamp_p1", -1, 1, 0);
    run_move("zero_steps", 0, 5, 0);
    check_idle("zero_after", 1);
  endtask

  task automatic test_abort;
    m_phase = wrap4(m_phase);
    run_move("abort_3rd", 10, 4, 3);
    check_idle("abort_hold", 2);
    run_move("abort_1st", -7, 3, 1);
    check_idle("abort1_hold", 1);
    abort = 1'b1;
    check_idle("abort_idle", 3);
    abort = 1'b0;
    run_move("min_neg", -64'sd2147483648, 2, 3);
    check_idle("min_neg_after", 1);
  endtask

  task automatic test_back_to_back;
    run_move("b2b_a", 3, 2, 0);
    run_move("b2b_b", -2, 3, 0);
    run_move("b2b_c", 5, 2, 0);
    check_idle("b2b_after", 1);
  endtask

  task automatic test_loopback;
    int s, p, ab_e;
    for (int i = 0; i < 16; i++) begin
      s = int'($urandom_range(0, 24)) - 12;
      p = int'($urandom_range(0, 20));
      ab_e = 0;
      if (s != 0 && $urandom_range(0, 3) == 0)
        ab_e = int'($urandom_range(1, (s < 0) ? -s : s));
      run_move($sformatf("rand%0d", i), s, p, ab_e);
      @(negedge clk);
      #1;
      checks++;
      if (dec_cnt !== m_pos || dec_fault !== 1'b0) begin
        errors++;
        $display("FAIL loop%0d dec=%0d fault=%b exp=%0d fault=0",
                 i, dec_cnt, dec_fault, m_pos);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [36:0] got;
    ifc.cmd_valid  = 1'b1;
    ifc.cmd_steps  = 32'd20;
    ifc.cmd_period = 16'd3;
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    got = {a, b, busy, done, ifc.cmd_ready, position};
    checks++;
    if (got !== {5'b00001, 32'd0}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", got, {5'b00001, 32'd0});
    end
    @(negedge clk);
    resetn = 1'b1;
    m_phase = 0;
    m_pos   = 0;
    @(posedge clk);
    #1;
    run_move("post_reset", 5, 3, 0);
    check_idle("post_reset_after", 1);
    @(negedge clk);
    #1;
    checks++;
    if (dec_cnt !== 5 || dec_fault !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_dec got=%0d fault=%b exp=5 fault=0",
               dec_cnt, dec_fault);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp_zero();
    test_abort();
    test_back_to_back();
    test_loopback();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_gen.md
Name: quad_gen

Overview:
- Quadrature signal generator: the transmit-side counterpart of the quad_enc decoder.
- Accepts signed step-count commands over a valid/ready handshake and emits A/B quadrature edges at a programmed clock-cycle spacing.
- Tracks emitted position; used for encoder emulation, loopback self-test of quad_enc, and driving downstream quadrature-input devices.

Parameters:
- WIDTH, 32, width of cmd_steps and position (two's complement).
- PERIOD_W, 16, width of cmd_period (clocks between successive edges).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  generator idle and able to accept a command.
- cmd_steps  input  WIDTH  signed edge count; sign gives direction.
- cmd_period  input  PERIOD_W  clocks per edge; values below 2 are clamped to 2.
- abort  input  1  stop the current move before its next edge.
- a  output  1  quadrature channel A, registered.
- b  output  1  quadrature channel B, registered.
- busy  output  1  move in progress.
- done  output  1  one-cycle pulse at move completion or abort.
- position  output  WIDTH  signed running count of emitted edges.

Behaviour:
- Reset is asynchronous, active-low; clk and resetn only.
- Reset values: a=0, b=0, busy=0, done=0, cmd_ready=1, position=0, phase=0, state IDLE.
- Reset mid-move discards the move; a and b return to 00 (position also clears to 0).

Phase and direction:
- Phase 0..3 maps to (a,b) = 00, 10, 11, 01.
- Positive steps: phase+1 mod 4; each edge increments position. This is the direction quad_enc counts up.
- Negative steps: phase-1 mod 4; each edge decrements position.
- Exactly one of a/b changes per edge; the outputs are glitch-free register outputs.

States:
- IDLE:
  - cmd_ready=1, busy=0.
  - Handshake occurs on cmd_valid && cmd_ready at a rising clk edge.
  - On accept, latch remaining=|cmd_steps| as unsigned WIDTH (so -2^(WIDTH-1) is representable), dir=sign, and per=max(cmd_period,2).
  - cmd_steps==0: stay IDLE; done=1 in the following cycle; no edges.
  - Otherwise go to RUN with timer=per-1.
- RUN:
  - cmd_ready=0, busy=1; the timer decrements each cycle.
  - On timer==0: update phase, update position by ±1, decrement remaining, reload timer=per-1.
  - The first edge appears on a/b exactly per cycles after the accept cycle; subsequent edges are spaced exactly per cycles.
  - The edge that makes remaining 0 also asserts done=1 and returns to IDLE in the same update, so cmd_ready=1 in that cycle and a back-to-back command may be accepted there.
- Abort:
  - abort sampled high in RUN returns to IDLE with done=1 in the next cycle.
  - abort wins over a coincident timer==0: that edge is not emitted.
  - a, b and position hold their last values.
  - abort in IDLE is ignored.

Other rules:
- position wraps two's complement with no saturation.
- cmd_steps and cmd_period are sampled only at accept; changes during RUN have no effect.
- Minimum period 2 guarantees quad_enc never sees both channels change between consecutive samples.

Test Plan:
1. Reset, then cmd_steps=+4, cmd_period=3 accepted at cycle T -> (a,b)=10,11,01,00 at T+3,T+6,T+9,T+12; position=4; done high only at T+12; cmd_ready high at T+12.
2. From phase 0, cmd_steps=-3, cmd_period=2 -> (a,b)=01,11,10 at T+2,T+4,T+6; position=-3; done at T+6.
3. cmd_period=0, cmd_steps=+2 -> edges at T+2 and T+4 (clamped); cmd_steps=0 -> done at T+1, no a/b change, busy stays 0.
4. cmd_steps=+10, period=4, abort asserted in the same cycle as the third timer expiry -> only 2 edges, position=2, (a,b)=11 held, done one cycle later.
5. Loopback of a/b into quad_enc (multiplier=1), random signed commands with period 2..20 -> quad_enc count equals position after each done; faultn stays 1.
6. resetn pulsed low asynchronously mid-move (between clock edges) -> a=b=0, busy=0, position=0 immediately; next command behaves as from reset.
